// File: rtl/iopad_ctrl_pkg.sv
// Shared types and constants for the I/O pad direction sequencer.
// Reset values are given per pad and replicated by each user to its bank width.
package iopad_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_SETTLE = 2'd2
  } iopad_state_e;

  localparam logic IOPAD_DIR_IN  = 1'b1;
  localparam logic IOPAD_DIR_OUT = 1'b0;

  // Per-pad reset values: every pad comes up as a tri-stated input.
  localparam logic PAD_DIR_RST = IOPAD_DIR_IN;
  localparam logic PAD_ZIN_RST = 1'b1;

endpackage

// File: rtl/iopad_turn_cnt.sv
// Down-counter that times the guard and settle intervals.
// A load sets it to TURN_CYCLES-1. Zero is flagged whenever the count is 0.
module iopad_turn_cnt #(
  parameter int TURN_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ZERO     = CW'(0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load has priority; decrementing saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != ZERO)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == ZERO);

endmodule

// File: rtl/iopad_dir_ctrl.sv
// Sequences direction changes for a bank of pads: it tri-states each pad that flips,
// then switches its direction, then waits out the settle interval before applying zin.
module iopad_dir_ctrl #(
  parameter int NUM_PADS    = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [NUM_PADS-1:0] cfg_dir,
  input  logic [NUM_PADS-1:0] cfg_zin,
  output logic [NUM_PADS-1:0] pad_dir,
  output logic [NUM_PADS-1:0] pad_zin,
  output logic                busy,
  output logic                done
);

  import iopad_ctrl_pkg::*;

  localparam logic [NUM_PADS-1:0] DIR_RST  = {NUM_PADS{PAD_DIR_RST}};
  localparam logic [NUM_PADS-1:0] ZIN_RST  = {NUM_PADS{PAD_ZIN_RST}};
  localparam logic [NUM_PADS-1:0] ALL_ZERO = {NUM_PADS{1'b0}};

  iopad_state_e        state_q, state_d;
  logic [NUM_PADS-1:0] pad_dir_q, pad_dir_d;
  logic [NUM_PADS-1:0] pad_zin_q, pad_zin_d;
  logic [NUM_PADS-1:0] req_dir_q, req_dir_d;
  logic [NUM_PADS-1:0] req_zin_q, req_zin_d;
  logic                done_q, done_d;
  logic [NUM_PADS-1:0] mask_s;
  logic                cnt_load_s;
  logic                cnt_dec_s;
  logic                cnt_zero_s;

  assign mask_s = cfg_dir ^ pad_dir_q;

  iopad_turn_cnt #(
    .TURN_CYCLES(TURN_CYCLES)
  ) u_turn_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load_s),
    .dec  (cnt_dec_s),
    .zero (cnt_zero_s)
  );

  // Next-state and output decode for the IDLE / GUARD / SETTLE sequencer.
  always_comb begin
    state_d    = state_q;
    pad_dir_d  = pad_dir_q;
    pad_zin_d  = pad_zin_q;
    req_dir_d  = req_dir_q;
    req_zin_d  = req_zin_q;
    done_d     = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          req_dir_d = cfg_dir;
          req_zin_d = cfg_zin;
          if (mask_s != ALL_ZERO) begin
            // Flipping pads go Z now; all other pads keep their state until the final apply.
            pad_zin_d  = pad_zin_q | mask_s;
            cnt_load_s = 1'b1;
            state_d    = ST_GUARD;
          end else begin
            pad_zin_d = cfg_zin;
            done_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (cnt_zero_s) begin
          pad_dir_d  = req_dir_q;
          cnt_load_s = 1'b1;
          state_d    = ST_SETTLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero_s) begin
          pad_zin_d = req_zin_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pad-output, request and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pad_dir_q <= DIR_RST;
      pad_zin_q <= ZIN_RST;
      req_dir_q <= ALL_ZERO;
      req_zin_q <= ALL_ZERO;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pad_dir_q <= pad_dir_d;
      pad_zin_q <= pad_zin_d;
      req_dir_q <= req_dir_d;
      req_zin_q <= req_zin_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign pad_dir   = pad_dir_q;
  assign pad_zin   = pad_zin_q;
  assign done      = done_q;

endmodule

// File: doc/iopad_dir_ctrl.md
# iopad_dir_ctrl

- Sequences direction and force-Z changes for a bank of `iopad` instances so that no pad switches direction while it drives.
- Every pad whose direction flips is first tri-stated through `zin` for a guard interval.
- The direction is then switched, and the pad is held in Z for a settle interval before the requested `zin` state is applied.
- The block sits between the configuration/scan logic and the I/O bank; its outputs drive `direction` and `zin` of each pad directly.

## Interface
- `NUM_PADS`, default 8: number of pads in the bank (≥1).
- `TURN_CYCLES`, default 2: length in cycles of each of the guard and settle intervals (≥1).
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cfg_valid` input 1: a request is present.
- `cfg_ready` output 1: the controller can accept a request; high exactly when in IDLE.
- `cfg_dir` input NUM_PADS: requested direction per pad (1 = input, 0 = output).
- `cfg_zin` input NUM_PADS: requested force-Z per pad (1 = Z).
- `pad_dir` output NUM_PADS: registered direction to each pad.
- `pad_zin` output NUM_PADS: registered `zin` to each pad.
- `busy` output 1: a transition is in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse when a request has fully taken effect.

## Operation
- **Reset values.**
  - `pad_dir` = all 1 (all inputs, safe).
  - `pad_zin` = all 1.
  - `busy` = 0, `done` = 0, state = IDLE, so `cfg_ready` = 1.
  - Internal request registers and the counter are cleared to 0.
- **States:** IDLE, GUARD, SETTLE.
- **Accept.** A request is accepted on a rising edge with `cfg_valid && cfg_ready`. On that edge:
  - latch `req_dir` = `cfg_dir` and `req_zin` = `cfg_zin`;
  - compute `mask = cfg_dir ^ pad_dir`, using the current `pad_dir`.
- **IDLE, mask ≠ 0.** On the accept edge: `pad_zin <= pad_zin | mask`, counter <= TURN_CYCLES-1, state <= GUARD.
- **IDLE, mask = 0.** On the accept edge: `pad_zin <= cfg_zin` and `done <= 1`; state stays IDLE.
- **GUARD.**
  - Counter decrements each cycle.
  - At counter = 0: `pad_dir <= req_dir`, counter <= TURN_CYCLES-1, state <= SETTLE.
  - `pad_zin` is unchanged throughout.
- **SETTLE.**
  - Counter decrements each cycle.
  - At counter = 0: `pad_zin <= req_zin`, `done <= 1`, state <= IDLE.
- **Unaffected pads.** Pads not in `mask` keep their prior `pad_zin` and `pad_dir` until the final apply edge. At that edge every pad takes its `req_zin`.
- **Requests during GUARD/SETTLE.** `cfg_valid` is ignored (`cfg_ready` = 0). The source holds the request until it is accepted; no queuing.
- **done.** Deasserts on the edge after it was set, unless a mask-zero request is accepted on that same edge, in which case it stays high for that request.
- **Back-to-back.** A request may be accepted on the first IDLE cycle after `done`.
- **Reset mid-transition.** All outputs return immediately (asynchronously) to their reset values; the pending request is discarded.

## Timing
- Edge 0 is the accept edge.
- **With direction changes:**
  - flipped pads go Z at edge 0;
  - `pad_dir` updates at edge TURN_CYCLES;
  - final `pad_zin` is applied and `done` rises at edge 2·TURN_CYCLES.
  - `busy` is high for 2·TURN_CYCLES cycles.
- **Without direction changes:** final `pad_zin` is applied and `done` rises at edge 0, i.e. latency 1; `busy` never rises.
- **Invariant:** at every edge where `pad_dir[i]` changes, `pad_zin[i]` is already 1 and stays 1 for at least TURN_CYCLES further cycles.
- **Outputs:** all outputs are registered except `cfg_ready` and `busy`, which decode the state register.

## Structure
- **Shared package `iopad_ctrl_pkg`:**
  - state enum (IDLE, GUARD, SETTLE);
  - localparams `IOPAD_DIR_IN` = 1 and `IOPAD_DIR_OUT` = 0;
  - the reset constants for `pad_dir` and `pad_zin`.
- **Sub-module `iopad_turn_cnt`:** down-counter with load and zero flag, width $clog2(TURN_CYCLES+1). It is instantiated once.
- **Top-level logic:** the FSM and the mask/request registers stay in the top module.

## Test plan
All scenarios use NUM_PADS=4 and TURN_CYCLES=2.

1. **Reset.**
   - Stimulus: assert `rst_n`=0 mid-cycle.
   - Response: immediately `pad_dir`=4'b1111, `pad_zin`=4'b1111, `busy`=0, `done`=0, `cfg_ready`=1.
2. **No-flip request.**
   - Stimulus: after reset, request `cfg_dir`=4'b1111, `cfg_zin`=4'b0000.
   - Response: `pad_zin`=0000 and `done`=1 the cycle after accept; `busy` stays 0.
3. **Flip request.**
   - Stimulus: from dir 1111/zin 0000, request dir 1010, zin 0000.
   - Response:
     - `pad_zin`=0101 after edge 0;
     - `pad_dir`=1010 after edge 2;
     - `pad_zin`=0000 and `done`=1 after edge 4;
     - `busy` high for 4 cycles.
4. **Request while busy.**
   - Stimulus: assert `cfg_valid` with dir 0000 during scenario 3.
   - Response: no accept until `cfg_ready`=1; then a new sequence with mask 1010.
5. **Reset in GUARD.**
   - Stimulus: drop `rst_n` one cycle after accepting dir 0000.
   - Response: outputs return to reset values; no `done` pulse.
6. **Invariant checker.**
   - Stimulus: random requests run continuously.
   - Response: the assertion holds that `pad_zin[i]`=1 on every edge where `pad_dir[i]` toggles, and for the TURN_CYCLES cycles after it.
